// File: rtl/ram_read_arbiter.sv
// Read arbiter sharing one external RAM port between the CPU and two auxiliary clients.
// Define ARB_AUX_STARVE_GUARD_EN to let aux clients in after 4 back-to-back CPU grants.
module ram_read_arbiter #(
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [24:0] cpu_addr,
  output logic        cpu_ack,
  input  logic [1:0]  aux_req,
  input  logic [24:0] aux_addr0,
  input  logic [24:0] aux_addr1,
  output logic [1:0]  aux_en,
  output logic [1:0]  aux_valid,
  output logic [7:0]  rdata,
  output logic        mem_rd,
  output logic [24:0] mem_addr,
  input  logic [7:0]  mem_din
);

  typedef enum logic [1:0] {StIdle, StCpuRd, StAuxRd, StDone} state_e;

  localparam logic [2:0] CntLoad = 3'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        last_aux_q, last_aux_d;
  logic        is_aux_q, is_aux_d;
  logic        sel_q, sel_d;
  logic [24:0] addr_q, addr_d;
  logic [7:0]  rdata_q, rdata_d;

  logic aux_any;
  logic aux_pick;
  logic starve_hit;
  logic grant_cpu;
  logic grant_aux;

  assign aux_any = |aux_req;
  // On a tie the client that did not win last time goes next.
  assign aux_pick = (aux_req == 2'b11) ? ~last_aux_q : aux_req[1];

`ifdef ARB_AUX_STARVE_GUARD_EN
  logic [2:0] starve_q, starve_d;

  assign starve_hit = (starve_q >= 3'd4);

  always_comb begin
    starve_d = starve_q;
    if (!aux_any || grant_aux) begin
      starve_d = 3'd0;
    end else if (grant_cpu && (starve_q != 3'd7)) begin
      starve_d = starve_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= 3'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  assign grant_cpu = (state_q == StIdle) && cpu_req && !(starve_hit && aux_any);
  assign grant_aux = (state_q == StIdle) && aux_any && !grant_cpu;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_aux_d = last_aux_q;
    is_aux_d   = is_aux_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    rdata_d    = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (grant_cpu) begin
          state_d  = StCpuRd;
          is_aux_d = 1'b0;
          addr_d   = cpu_addr;
          cnt_d    = CntLoad;
        end else if (grant_aux) begin
          state_d    = StAuxRd;
          is_aux_d   = 1'b1;
          sel_d      = aux_pick;
          last_aux_d = aux_pick;
          addr_d     = aux_pick ? aux_addr1 : aux_addr0;
          cnt_d      = CntLoad;
        end
      end
      StCpuRd, StAuxRd: begin
        if (cnt_q == 3'd0) begin
          state_d = StDone;
          rdata_d = mem_din;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 3'd0;
      last_aux_q <= 1'b1;
      is_aux_q   <= 1'b0;
      sel_q      <= 1'b0;
      addr_q     <= 25'd0;
      rdata_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_aux_q <= last_aux_d;
      is_aux_q   <= is_aux_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      rdata_q    <= rdata_d;
    end
  end

  logic [1:0] sel_onehot;
  logic       aux_window;

  assign sel_onehot = sel_q ? 2'b10 : 2'b01;
  assign aux_window = (state_q == StAuxRd) || ((state_q == StDone) && is_aux_q);

  assign mem_rd    = (state_q == StCpuRd) || (state_q == StAuxRd);
  assign mem_addr  = addr_q;
  assign rdata     = rdata_q;
  assign cpu_ack   = (state_q == StDone) && !is_aux_q;
  assign aux_en    = aux_window ? sel_onehot : 2'b00;
  assign aux_valid = ((state_q == StDone) && is_aux_q) ? sel_onehot : 2'b00;

endmodule

// File: tb/tb_ram_read_arbiter.sv
// Self-checking bench for ram_read_arbiter: vector table, corner sequences, random vs timeline model.
module tb_ram_read_arbiter;

  localparam int unsigned LAT = 3;
`ifdef ARB_AUX_STARVE_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic [24:0] cpu_addr = '0;
  logic        cpu_ack;
  logic [1:0]  aux_req = '0;
  logic [24:0] aux_addr0 = '0;
  logic [24:0] aux_addr1 = '0;
  logic [1:0]  aux_en;
  logic [1:0]  aux_valid;
  logic [7:0]  rdata;
  logic        mem_rd;
  logic [24:0] mem_addr;
  logic [7:0]  mem_din = '0;

  ram_read_arbiter #(.LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack),
    .aux_req(aux_req), .aux_addr0(aux_addr0), .aux_addr1(aux_addr1), .aux_en(aux_en),
    .aux_valid(aux_valid), .rdata(rdata), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_din(mem_din)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // cli: 0 cpu, 1 tape, 2 loader
  typedef struct {
    logic        cpu;
    logic [1:0]  aux;
    logic [24:0] ca;
    logic [24:0] a0;
    logic [24:0] a1;
    logic [7:0]  din;
    int          cli;
    logic [24:0] eaddr;
    logic [7:0]  erdata;
  } vec_t;

  vec_t vecs[7];

  // Entered and left at a negedge with the DUT idle.
  task automatic run_vec(input vec_t v, input int idx);
    logic [1:0] en_exp;
    en_exp = (v.cli == 1) ? 2'b01 : ((v.cli == 2) ? 2'b10 : 2'b00);
    cpu_req = v.cpu; aux_req = v.aux; cpu_addr = v.ca;
    aux_addr0 = v.a0; aux_addr1 = v.a1; mem_din = v.din;
    for (int k = 1; k <= int'(LAT); k++) begin
      @(negedge clk);
      check($sformatf("v%0d_rd%0d", idx, k), {mem_rd, aux_en, mem_addr}, {1'b1, en_exp, v.eaddr});
    end
    @(negedge clk);
    check($sformatf("v%0d_done", idx), {cpu_ack, aux_valid, aux_en, mem_rd},
          {(v.cli == 0), en_exp, en_exp, 1'b0});
    check($sformatf("v%0d_rdata", idx), rdata, v.erdata);
    cpu_req = 1'b0; aux_req = 2'b00;
    mem_din = 8'hEE;
    @(negedge clk);
    check($sformatf("v%0d_idle", idx), {mem_rd, aux_en, cpu_ack, aux_valid, rdata},
          {1'b0, 2'b00, 1'b0, 2'b00, v.erdata});
  endtask

  // Timeline model state for the random phase
  int          cyc, t0, cli, pick, starve;
  bit          busy, last, force_aux;
  logic [24:0] m_addr;
  logic [7:0]  m_rdata;
  logic        e_rd, e_done, e_ack;
  logic [1:0]  e_en, e_val;

  initial begin
    int  cpu_cnt;
    bit  tape_seen;
    logic bad;

    vecs[0] = '{1'b1, 2'b00, 25'h0000100, 25'h0, 25'h0, 8'hA5, 0, 25'h0000100, 8'hA5};
    vecs[1] = '{1'b0, 2'b11, 25'h0, 25'h0400000, 25'h0500000, 8'h11, 1, 25'h0400000, 8'h11};
    vecs[2] = '{1'b0, 2'b11, 25'h0, 25'h0400000, 25'h0500000, 8'h22, 2, 25'h0500000, 8'h22};
    vecs[3] = '{1'b0, 2'b11, 25'h0, 25'h0400000, 25'h0500000, 8'h33, 1, 25'h0400000, 8'h33};
    vecs[4] = '{1'b1, 2'b11, 25'h1FFFFFF, 25'h0400000, 25'h0500000, 8'hFF, 0, 25'h1FFFFFF, 8'hFF};
    vecs[5] = '{1'b0, 2'b10, 25'h0, 25'h0, 25'h0000001, 8'h00, 2, 25'h0000001, 8'h00};
    vecs[6] = '{1'b0, 2'b01, 25'h0, 25'h1000000, 25'h0, 8'h5A, 1, 25'h1000000, 8'h5A};

    repeat (3) @(negedge clk);
    check("reset_state", {mem_rd, mem_addr, cpu_ack, aux_en, aux_valid, rdata}, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // CPU request arriving mid aux read waits for the tape transfer
    aux_req = 2'b01; aux_addr0 = 25'h0222222; mem_din = 8'h6B;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 25'h0001234;
    for (int k = 2; k <= int'(LAT); k++) @(negedge clk);
    @(negedge clk);
    check("cpu_wait_done", {aux_valid, cpu_ack, rdata}, {2'b01, 1'b0, 8'h6B});
    aux_req = 2'b00;
    @(negedge clk);
    check("cpu_wait_idle", {mem_rd, aux_en}, 3'b000);
    @(negedge clk);
    check("cpu_wait_grant", {mem_rd, aux_en, mem_addr}, {1'b1, 2'b00, 25'h0001234});
    for (int k = 2; k <= int'(LAT); k++) @(negedge clk);
    @(negedge clk);
    check("cpu_wait_ack", {cpu_ack, aux_valid}, 3'b100);
    cpu_req = 1'b0;
    @(negedge clk);

    // Reset in the second CPU read cycle aborts silently
    cpu_req = 1'b1; cpu_addr = 25'h0ABCDEF; mem_din = 8'h99;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid", {mem_rd, mem_addr, cpu_ack, aux_en, aux_valid, rdata}, 64'd0);
    reset = 1'b0; cpu_req = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (cpu_ack || mem_rd) bad = 1'b1;
    end
    check("reset_no_ack", bad, 1'b0);

    // Loader drops its request one cycle after grant
    aux_req = 2'b10; aux_addr1 = 25'h00ABCDE; mem_din = 8'h3C;
    @(negedge clk);
    check("drop_grant", {mem_rd, aux_en, mem_addr}, {1'b1, 2'b10, 25'h00ABCDE});
    aux_req = 2'b00;
    for (int k = 2; k <= int'(LAT); k++) @(negedge clk);
    @(negedge clk);
    check("drop_valid", {aux_valid, rdata}, {2'b10, 8'h3C});
    @(negedge clk);

    // CPU hogging with tape pending
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cpu_req = 1'b1; aux_req = 2'b01; cpu_addr = 25'h0000042; aux_addr0 = 25'h0000077;
    cpu_cnt = 0; tape_seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cpu_ack) cpu_cnt++;
      if (aux_valid[0]) tape_seen = 1'b1;
      if (tape_seen || cpu_cnt >= 8) break;
    end
    check("starve_tape", tape_seen, Guard);
    check("starve_cpu_cnt", 64'(cpu_cnt), Guard ? 64'd4 : 64'd8);
    cpu_req = 1'b0; aux_req = 2'b00;
    @(negedge clk);

    // Random phase against a transaction timeline model
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    busy = 1'b0; last = 1'b1; starve = 0; m_addr = '0; m_rdata = '0; cyc = 0;
    t0 = 0; cli = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (busy && cyc > t0 + int'(LAT) + 1) busy = 1'b0;
      e_rd   = busy && cyc >= t0 + 1 && cyc <= t0 + int'(LAT);
      e_done = busy && cyc == t0 + int'(LAT) + 1;
      e_en   = (busy && cli != 0 && cyc >= t0 + 1) ? ((cli == 1) ? 2'b01 : 2'b10) : 2'b00;
      e_ack  = e_done && cli == 0;
      e_val  = e_done ? e_en : 2'b00;
      check($sformatf("rnd_c%0d", cyc), {mem_rd, mem_addr, cpu_ack, aux_en, aux_valid, rdata},
            {e_rd, m_addr, e_ack, e_en, e_val, m_rdata});

      if (e_ack) cpu_req = ($urandom_range(0, 1) == 1);
      else if (!cpu_req) cpu_req = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) cpu_addr = 25'($urandom);
      for (int g = 0; g < 2; g++) begin
        if (e_val[g]) aux_req[g] = ($urandom_range(0, 1) == 1);
        else if (!aux_req[g]) aux_req[g] = ($urandom_range(0, 2) == 0);
        else if (busy && cli == g + 1 && $urandom_range(0, 7) == 0) aux_req[g] = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) aux_addr0 = 25'($urandom);
      if ($urandom_range(0, 3) == 0) aux_addr1 = 25'($urandom);
      mem_din = 8'($urandom);

      if (busy && cyc == t0 + int'(LAT)) m_rdata = mem_din;
      if (aux_req == 2'b00) starve = 0;
      if (!busy) begin
        force_aux = Guard && starve >= 4 && aux_req != 2'b00;
        if (cpu_req && !force_aux) begin
          busy = 1'b1; t0 = cyc; cli = 0; m_addr = cpu_addr;
          if (aux_req != 2'b00 && starve < 7) starve++;
        end else if (aux_req != 2'b00) begin
          pick = (aux_req == 2'b11) ? (last ? 0 : 1) : (aux_req[1] ? 1 : 0);
          last = (pick == 1);
          cli = pick + 1; busy = 1'b1; t0 = cyc; starve = 0;
          m_addr = (pick == 1) ? aux_addr1 : aux_addr0;
        end
      end
      cyc++;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
